// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: shares the register-file write port between pipeline writeback and the MDU.
// Define REG_WB_SCOREBOARD_EN to build the busy-register scoreboard (BUSY_MASK/HAZARD).
module reg_wb_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        PIPE_WE,
    input  logic [4:0]  PIPE_ADDR,
    input  logic [31:0] PIPE_DATA,
    input  logic        MDU_VALID,
    input  logic [4:0]  MDU_ADDR,
    input  logic [31:0] MDU_DATA,
    output logic        MDU_READY,
    input  logic        ISSUE_VALID,
    input  logic [4:0]  ISSUE_ADDR,
    input  logic [4:0]  RS1_ADDR,
    input  logic [4:0]  RS2_ADDR,
    output logic        HAZARD,
    output logic [31:0] BUSY_MASK,
    output logic        STALL_REQ,
    output logic        WRITE_ENABLE,
    output logic [4:0]  WRITE_ADDRESS,
    output logic [31:0] WRITE_DATA
);
    typedef enum logic [1:0] {EMPTY, HOLD, FORCE} state_t;
    state_t      state, state_nxt;
    logic [3:0]  wait_cnt, wait_nxt;
    logic [4:0]  buf_addr;
    logic [31:0] buf_data;
    logic        pipe_eff, grant, accept, mdu_wr;
    assign pipe_eff  = PIPE_WE && (PIPE_ADDR != 5'd0);
    assign grant     = (state != EMPTY) && !pipe_eff;
    assign MDU_READY = (state == EMPTY) || grant;
    assign accept    = MDU_VALID && MDU_READY;
    assign mdu_wr    = grant && (buf_addr != 5'd0);
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        if (state == EMPTY) begin
            state_nxt = accept ? HOLD : EMPTY;
            wait_nxt  = '0;
        end else if (grant) begin
            state_nxt = accept ? HOLD : EMPTY;
            wait_nxt  = '0;
        end else if (state == HOLD) begin
            wait_nxt  = wait_cnt + 4'd1;
            state_nxt = (wait_nxt == 4'(STARVE_LIMIT)) ? FORCE : HOLD;
        end
    end
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= EMPTY;
            wait_cnt      <= '0;
            buf_addr      <= '0;
            buf_data      <= '0;
            STALL_REQ     <= 1'b0;
            WRITE_ENABLE  <= 1'b0;
            WRITE_ADDRESS <= '0;
            WRITE_DATA    <= '0;
        end else begin
            state        <= state_nxt;
            wait_cnt     <= wait_nxt;
            STALL_REQ    <= (state_nxt == FORCE);
            WRITE_ENABLE <= pipe_eff || mdu_wr;
            if (accept) begin
                buf_addr <= MDU_ADDR;
                buf_data <= MDU_DATA;
            end
            if (pipe_eff) begin
                WRITE_ADDRESS <= PIPE_ADDR;
                WRITE_DATA    <= PIPE_DATA;
            end else if (mdu_wr) begin
                WRITE_ADDRESS <= buf_addr;
                WRITE_DATA    <= buf_data;
            end
        end
    end
`ifdef REG_WB_SCOREBOARD_EN
    logic [31:0] busy, set_mask, clr_mask;
    // set is applied after clear so a same-cycle issue keeps the bit
    assign set_mask  = ISSUE_VALID ? (32'd1 << ISSUE_ADDR) : '0;
    assign clr_mask  = grant ? (32'd1 << buf_addr) : '0;
    assign BUSY_MASK = busy;
    assign HAZARD    = busy[RS1_ADDR] | busy[RS2_ADDR];
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            busy <= '0;
        else
            busy <= ((busy & ~clr_mask) | set_mask) & ~32'd1;
    end
`else
    logic unused_sb;
    assign unused_sb = ^{ISSUE_VALID, ISSUE_ADDR, RS1_ADDR, RS2_ADDR};
    assign BUSY_MASK = '0;
    assign HAZARD    = 1'b0;
`endif
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb_reg_wb_arbiter: directed stimulus with a write-port scoreboard queue for reg_wb_arbiter.
module tb_reg_wb_arbiter;
    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        PIPE_WE, MDU_VALID, ISSUE_VALID;
    logic [4:0]  PIPE_ADDR, MDU_ADDR, ISSUE_ADDR, RS1_ADDR, RS2_ADDR;
    logic [31:0] PIPE_DATA, MDU_DATA;
    logic        MDU_READY, HAZARD, STALL_REQ, WRITE_ENABLE;
    logic [31:0] BUSY_MASK, WRITE_DATA;
    logic [4:0]  WRITE_ADDRESS;
    logic [36:0] exp_q[$];
    logic [36:0] exp_w;
    int checks = 0;
    int errors = 0;

    reg_wb_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .PIPE_WE(PIPE_WE), .PIPE_ADDR(PIPE_ADDR), .PIPE_DATA(PIPE_DATA),
        .MDU_VALID(MDU_VALID), .MDU_ADDR(MDU_ADDR), .MDU_DATA(MDU_DATA), .MDU_READY(MDU_READY),
        .ISSUE_VALID(ISSUE_VALID), .ISSUE_ADDR(ISSUE_ADDR),
        .RS1_ADDR(RS1_ADDR), .RS2_ADDR(RS2_ADDR),
        .HAZARD(HAZARD), .BUSY_MASK(BUSY_MASK), .STALL_REQ(STALL_REQ),
        .WRITE_ENABLE(WRITE_ENABLE), .WRITE_ADDRESS(WRITE_ADDRESS), .WRITE_DATA(WRITE_DATA)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic drive_pipe(input logic we, input logic [4:0] a, input logic [31:0] d);
        PIPE_WE = we;
        PIPE_ADDR = a;
        PIPE_DATA = d;
        if (we && a != 5'd0) push(a, d);
    endtask

    task automatic drive_mdu(input logic v, input logic [4:0] a, input logic [31:0] d);
        MDU_VALID = v;
        MDU_ADDR = a;
        MDU_DATA = d;
    endtask

    // every register-file write must match the oldest outstanding expectation
    always @(negedge CLK) begin
        if (RESET_N === 1'b1 && WRITE_ENABLE === 1'b1) begin
            check("wr_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                exp_w = exp_q.pop_front();
                check("wr_addr", 32'(WRITE_ADDRESS), 32'(exp_w[36:32]));
                check("wr_data", WRITE_DATA, exp_w[31:0]);
            end
        end
    end

    initial begin
        RESET_N = 1'b0;
        drive_pipe(1'b0, 5'd0, 32'd0);
        drive_mdu(1'b0, 5'd0, 32'd0);
        ISSUE_VALID = 1'b0; ISSUE_ADDR = 5'd0; RS1_ADDR = 5'd0; RS2_ADDR = 5'd0;
        repeat (2) tick();
        check("rst_we", 32'(WRITE_ENABLE), 32'd0);
        check("rst_addr", 32'(WRITE_ADDRESS), 32'd0);
        check("rst_data", WRITE_DATA, 32'd0);
        check("rst_busy", BUSY_MASK, 32'd0);
        check("rst_stall", 32'(STALL_REQ), 32'd0);
        check("rst_ready", 32'(MDU_READY), 32'd1);
        RESET_N = 1'b1;

        drive_pipe(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        check("pipe_we", 32'(WRITE_ENABLE), 32'd1);
        check("pipe_addr", 32'(WRITE_ADDRESS), 32'd5);
        check("pipe_data", WRITE_DATA, 32'hDEADBEEF);
        drive_pipe(1'b1, 5'd0, 32'h11111111);
        tick();
        check("x0_we", 32'(WRITE_ENABLE), 32'd0);
        check("hold_addr", 32'(WRITE_ADDRESS), 32'd5);
        check("hold_data", WRITE_DATA, 32'hDEADBEEF);

        // contention: pipe busy for 3 cycles, result x7 waits
        drive_pipe(1'b1, 5'd1, 32'hA1);
        drive_mdu(1'b1, 5'd7, 32'h12345678);
        tick();
        drive_mdu(1'b0, 5'd0, 32'd0);
        drive_pipe(1'b1, 5'd2, 32'hA2);
        tick();
        check("cont_stall1", 32'(STALL_REQ), 32'd0);
        drive_pipe(1'b1, 5'd3, 32'hA3);
        tick();
        check("cont_stall2", 32'(STALL_REQ), 32'd0);
        drive_pipe(1'b0, 5'd0, 32'd0);
        push(5'd7, 32'h12345678);
        #1 check("cont_ready", 32'(MDU_READY), 32'd1);
        tick();
        check("cont_we", 32'(WRITE_ENABLE), 32'd1);
        check("cont_addr", 32'(WRITE_ADDRESS), 32'd7);
        check("cont_stall3", 32'(STALL_REQ), 32'd0);

        // starvation: pipe held high until STALL_REQ has risen
        drive_pipe(1'b1, 5'd10, 32'h1000);
        drive_mdu(1'b1, 5'd7, 32'hCAFEF00D);
        tick();
        drive_mdu(1'b0, 5'd0, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            drive_pipe(1'b1, 5'd10, 32'h1000 + 32'(i));
            tick();
            check("starve_stall", 32'(STALL_REQ), 32'(i >= 4));
            if (i == 4) check("starve_ready", 32'(MDU_READY), 32'd0);
        end
        drive_pipe(1'b0, 5'd0, 32'd0);
        push(5'd7, 32'hCAFEF00D);
        #1 check("starve_ready_grant", 32'(MDU_READY), 32'd1);
        tick();
        check("starve_we", 32'(WRITE_ENABLE), 32'd1);
        check("starve_data", WRITE_DATA, 32'hCAFEF00D);
        check("starve_stall_fall", 32'(STALL_REQ), 32'd0);

        // back-to-back MDU results
        drive_mdu(1'b1, 5'd3, 32'h33);
        tick();
        drive_mdu(1'b1, 5'd4, 32'h44);
        push(5'd3, 32'h33);
        #1 check("b2b_ready", 32'(MDU_READY), 32'd1);
        tick();
        check("b2b_addr3", 32'(WRITE_ADDRESS), 32'd3);
        drive_mdu(1'b0, 5'd0, 32'd0);
        push(5'd4, 32'h44);
        tick();
        check("b2b_we4", 32'(WRITE_ENABLE), 32'd1);
        check("b2b_addr4", 32'(WRITE_ADDRESS), 32'd4);

        // MDU result to x0 is accepted and dropped
        drive_mdu(1'b1, 5'd0, 32'h99);
        tick();
        drive_mdu(1'b0, 5'd0, 32'd0);
        tick();
        check("mdu_x0_we", 32'(WRITE_ENABLE), 32'd0);
        check("mdu_x0_data", WRITE_DATA, 32'h44);

        ISSUE_VALID = 1'b1; ISSUE_ADDR = 5'd9; RS1_ADDR = 5'd9;
        tick();
        ISSUE_VALID = 1'b0;
`ifdef REG_WB_SCOREBOARD_EN
        #1 check("sb_hazard_set", 32'(HAZARD), 32'd1);
        check("sb_busy_set", BUSY_MASK, 32'h200);
        drive_pipe(1'b1, 5'd1, 32'hB1);
        drive_mdu(1'b1, 5'd9, 32'h99);
        tick();
        drive_pipe(1'b0, 5'd0, 32'd0);
        drive_mdu(1'b0, 5'd0, 32'd0);
        push(5'd9, 32'h99);
        #1 check("sb_hazard_wait", 32'(HAZARD), 32'd1);
        tick();
        check("sb_hazard_clr", 32'(HAZARD), 32'd0);
        ISSUE_VALID = 1'b1;
        tick();
        ISSUE_VALID = 1'b0;
        drive_mdu(1'b1, 5'd9, 32'h98);
        tick();
        drive_mdu(1'b0, 5'd0, 32'd0);
        ISSUE_VALID = 1'b1;
        push(5'd9, 32'h98);
        tick();
        ISSUE_VALID = 1'b0;
        #1 check("sb_set_wins", BUSY_MASK, 32'h200);
        check("sb_hazard_kept", 32'(HAZARD), 32'd1);
`else
        #1 check("nosb_hazard", 32'(HAZARD), 32'd0);
        check("nosb_busy", BUSY_MASK, 32'd0);
`endif

        // reset in mid-HOLD drops the buffer and busy bits
        ISSUE_VALID = 1'b1; ISSUE_ADDR = 5'd5;
        tick();
        ISSUE_VALID = 1'b0;
        drive_pipe(1'b1, 5'd2, 32'hC2);
        drive_mdu(1'b1, 5'd5, 32'h55);
        tick();
`ifdef REG_WB_SCOREBOARD_EN
        check("pre_rst_busy5", 32'(BUSY_MASK[5]), 32'd1);
`endif
        @(negedge CLK);
        #1;
        RESET_N = 1'b0;
        drive_pipe(1'b0, 5'd0, 32'd0);
        drive_mdu(1'b0, 5'd0, 32'd0);
        #1 check("mid_rst_we", 32'(WRITE_ENABLE), 32'd0);
        check("mid_rst_busy", BUSY_MASK, 32'd0);
        check("mid_rst_ready", 32'(MDU_READY), 32'd1);
        tick();
        RESET_N = 1'b1;
        #1 check("post_rst_ready", 32'(MDU_READY), 32'd1);
        check("post_rst_hazard", 32'(HAZARD), 32'd0);
        repeat (3) tick();
        check("post_rst_we", 32'(WRITE_ENABLE), 32'd0);
        check("q_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

Shares the single write port of the 32 x 32 register file between two producers: the in-order pipeline writeback stage and the multi-cycle M-extension unit (MUL/DIV). It sits between writeback and the register file, buffers one MDU result, and drives the file's registered WRITE_ENABLE/WRITE_ADDRESS/WRITE_DATA. It also keeps a scoreboard of destination registers with an MDU result still outstanding, so decode can stall on read-after-write hazards.

## Interface
- STARVE_LIMIT, 4: number of cycles a buffered MDU result may wait behind pipeline writes before STALL_REQ is raised (1..15).
- CLK  in  1  clock; all state updates on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- PIPE_WE  in  1  pipeline writeback request; cannot be back-pressured.
- PIPE_ADDR  in  5  pipeline destination register.
- PIPE_DATA  in  32  pipeline writeback data.
- MDU_VALID  in  1  MDU result valid.
- MDU_ADDR  in  5  MDU destination register.
- MDU_DATA  in  32  MDU result.
- MDU_READY  out  1  arbiter can accept an MDU result this cycle.
- ISSUE_VALID  in  1  an MDU op is issued this cycle.
- ISSUE_ADDR  in  5  destination register of the issued op.
- RS1_ADDR, RS2_ADDR  in  5 each  decode-stage source registers.
- HAZARD  out  1  a source register has a pending MDU result.
- BUSY_MASK  out  32  one bit per register: MDU result outstanding.
- STALL_REQ  out  1  request for a writeback bubble.
- WRITE_ENABLE  out  1  register-file write enable.
- WRITE_ADDRESS  out  5  register-file write address.
- WRITE_DATA  out  32  register-file write data.

## Operation
- A pipeline request is effective only when PIPE_WE=1 and PIPE_ADDR!=0. A request to x0 counts as idle.
- A buffered MDU result is granted when no effective pipeline request is present. Pipeline requests always win.
- MDU handshake: transfer on MDU_VALID & MDU_READY at the clock edge. The result is captured into a one-entry buffer.
- MDU_READY = buffer empty, or buffer is being granted this cycle. This allows back-to-back acceptance.
- A result with MDU_ADDR=0 is accepted and then discarded on grant. It produces no WRITE_ENABLE.
- Buffer state machine:
  - EMPTY: buffer empty; accept -> HOLD.
  - HOLD: grant with no new accept -> EMPTY. Grant with a new accept -> HOLD, with the wait counter cleared. Otherwise the wait counter increments; when it reaches STARVE_LIMIT -> FORCE.
  - FORCE: STALL_REQ=1. Grant -> EMPTY, or -> HOLD if a new result is accepted in the same cycle.
- Upstream contract: PIPE_WE is deasserted no later than 2 cycles after STALL_REQ rises.
- Scoreboard:
  - ISSUE_VALID with ISSUE_ADDR!=0 sets BUSY_MASK[ISSUE_ADDR].
  - Granting an MDU result clears the bit for its address.
  - If set and clear hit the same address in the same cycle, set wins.
  - Bit 0 is always 0.
- HAZARD = BUSY_MASK[RS1_ADDR] | BUSY_MASK[RS2_ADDR]. It is combinational from current mask state.

## Timing
- Reset (asynchronous, RESET_N=0) immediately forces:
  - WRITE_ENABLE=0, WRITE_ADDRESS=0, WRITE_DATA=0;
  - BUSY_MASK=0, STALL_REQ=0, HAZARD=0;
  - state EMPTY, wait counter 0, buffer dropped. MDU_READY=1 once the combinational path settles.
- A reset in the middle of an operation discards any buffered result and all busy bits. The MDU side must re-issue.
- Write outputs are registered, with 1-cycle latency. A pipeline request in cycle N appears on WRITE_* in cycle N+1, and the register file samples it at the next edge.
- MDU path: accepted at edge N; granted in cycle N+1 if the pipeline is idle; on WRITE_* in cycle N+2.
- When no grant occurs, WRITE_ENABLE=0 and WRITE_ADDRESS/WRITE_DATA hold their previous values.
- STALL_REQ is registered. It rises in the cycle after the wait counter reaches STARVE_LIMIT and falls in the cycle after the grant.

## Configuration
- REG_WB_SCOREBOARD_EN defined: scoreboard, BUSY_MASK and HAZARD operate as described.
- Not defined: no scoreboard state is built, BUSY_MASK=0 and HAZARD=0 at all times. The ISSUE_* and RS* inputs are ignored. Arbitration is unchanged.

## Test plan
- Reset: RESET_N=0 in mid-HOLD with BUSY_MASK=0x0000_0020 -> WRITE_ENABLE=0, BUSY_MASK=0, MDU_READY=1 immediately after reset release.
- Pipeline only: PIPE_WE=1, PIPE_ADDR=5, PIPE_DATA=0xDEADBEEF -> next cycle WRITE_ENABLE=1, WRITE_ADDRESS=5, WRITE_DATA=0xDEADBEEF. Repeat with PIPE_ADDR=0 -> WRITE_ENABLE stays 0.
- Contention: MDU result (x7, 0x12345678) accepted while PIPE_WE=1 for 3 cycles, STARVE_LIMIT=4 -> x7 appears on WRITE_* 1 cycle after PIPE_WE falls; STALL_REQ never rises.
- Starvation: PIPE_WE held high -> STALL_REQ=1 on the 5th cycle after acceptance, MDU_READY=0. Drop PIPE_WE -> MDU write of x7 appears, STALL_REQ returns to 0.
- Back-to-back MDU: two consecutive results (x3, x4) with the pipeline idle -> MDU_READY stays 1, writes x3 then x4 on consecutive cycles.
- Scoreboard (macro defined): issue to x9, RS1_ADDR=9 -> HAZARD=1 until the cycle after the x9 grant. Issue to x9 on the same cycle as the x9 grant -> bit 9 stays set.
